eth_tx_sched: RTL
=================

ETH_TX_SCHED -- requirements
Module: eth_tx_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one eth_tx (2..8).
REQ-002 SHALL have parameter FRAME_CYCLES, default 8, clk cycles the transmitter occupies after a start pulse (>=1).
REQ-003 SHALL have parameter IFG_CYCLES, default 3, enforced idle gap after each frame (>=0).
REQ-004 SHALL have port clk  input  1  single clock, the transmitter's clock; all logic on posedge clk.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  permits new grants when high.
REQ-007 SHALL have port req  input  NREQ  level request per requester.
REQ-008 SHALL have port gnt  output  NREQ  one-hot, one-cycle grant pulse coincident with start.
REQ-009 SHALL have port start  output  1  one-cycle start pulse to the eth_tx start input.
REQ-010 SHALL have port sel  output  $clog2(NREQ)  index of current owner, held from START through GAP.
REQ-011 SHALL have port busy  output  1  high in START, FRAME and GAP states.

Function
REQ-012 SHALL implement FSM states IDLE, START, FRAME, GAP.
REQ-013 IDLE: if enable and |req, SHALL register round-robin winner into sel and go to START next cycle; else stay.
REQ-014 START: SHALL assert start and gnt[sel] for exactly one cycle, load counter with FRAME_CYCLES-1, go to FRAME.
REQ-015 FRAME: SHALL decrement counter; at 0 go to GAP loading IFG_CYCLES-1, or to IDLE directly if IFG_CYCLES==0.
REQ-016 GAP: SHALL decrement counter; at 0 go to IDLE.
REQ-017 Latency: req sampled high in IDLE at edge t SHALL produce start/gnt in cycle t+1.
REQ-018 Start-to-start spacing SHALL be exactly FRAME_CYCLES+IFG_CYCLES+2 cycles under continuous requests.
REQ-019 Round-robin: after granting index i, priority SHALL begin at i+1 modulo NREQ; pointer wraps NREQ-1 -> 0.
REQ-020 req is level-sensitive; a requester still high after its gnt SHALL be eligible again only per REQ-019.
REQ-021 req changes outside IDLE SHALL be ignored until next IDLE evaluation.
REQ-022 enable deasserted in START/FRAME/GAP SHALL NOT abort the frame or gap; FSM returns to IDLE and holds.
REQ-023 Counter width SHALL be $clog2(max(FRAME_CYCLES,IFG_CYCLES)+1) bits, no overflow possible.
REQ-024 gnt SHALL be zero whenever start is low.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, start=0, gnt=0, busy=0, sel=0, counter=0, RR pointer=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; first grant after release follows REQ-017 with pointer at 0.

Configuration
REQ-027 With ETH_TX_SCHED_STATS_EN defined, SHALL add output frame_cnt [15:0], reset 0, incremented on each start, wrapping 16'hFFFF -> 0.
REQ-028 Without ETH_TX_SCHED_STATS_EN, frame_cnt port and its logic SHALL be absent; other behaviour identical.

Structure
REQ-029 FSM state encoding and default parameter constants SHALL live in shared package eth_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_arb (inputs req, pointer; output one-hot winner and index).

Verification (NREQ=4, FRAME_CYCLES=8, IFG_CYCLES=3)
REQ-031 rst_n pulsed low -> start, gnt, busy, sel all 0 during and after reset, no start while req=0.
REQ-032 req=4'b0100, enable=1 from IDLE at edge t -> start=1, gnt=4'b0100, sel=2 in cycle t+1; busy high 12 cycles.
REQ-033 req=4'b1111 held -> grants 0,1,2,3,0 in order, start pulses exactly 13 cycles apart.
REQ-034 enable=0 with req=4'b0001 -> no start; enable dropped 2 cycles after start -> frame and gap complete, then no further start.
REQ-035 rst_n low during FRAME -> busy=0 immediately; after release with req=4'b1000 grant goes to index 3 within 1 cycle of IDLE.
REQ-036 ETH_TX_SCHED_STATS_EN defined, 3 frames sent -> frame_cnt=3; preloaded 16'hFFFF plus one start -> 0.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the eth_tx scheduler: FSM state encoding,
// default parameter constants and a small helper for sizing counters.
package eth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_FRAME = 2'd2,
      ST_GAP   = 2'd3
   } sched_state_t;

   localparam int DEF_NREQ         = 4;
   localparam int DEF_FRAME_CYCLES = 8;
   localparam int DEF_IFG_CYCLES   = 3;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker: searches req starting at ptr and wrapping, returns
// the first requester found as a one-hot vector and as an index.
module rr_arb
   import eth_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   localparam int IW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] winner,
   output logic [IW-1:0]   idx
);

   logic          found;
   logic [IW-1:0] pos;

   // Walk the requesters in priority order beginning at ptr; first hit wins
   always_comb begin
      winner = '0;
      idx    = '0;
      found  = 1'b0;
      pos    = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = IW'((int'(ptr) + k) % NREQ);
         if (!found && req[pos]) begin
            winner[pos] = 1'b1;
            idx         = pos;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth_tx_sched.sv
// Shares one eth_tx among NREQ requesters: round-robin grant, one-cycle
// start pulse, then the frame time and inter-frame gap are waited out.
// Optional frame counter output enabled by defining ETH_TX_SCHED_STATS_EN.
module eth_tx_sched
   import eth_pkg::*;
#(
   parameter int NREQ         = DEF_NREQ,
   parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
   parameter int IFG_CYCLES   = DEF_IFG_CYCLES
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [NREQ-1:0]          req,
   output logic [NREQ-1:0]          gnt,
   output logic                     start,
   output logic [$clog2(NREQ)-1:0]  sel,
   output logic                     busy
`ifdef ETH_TX_SCHED_STATS_EN
   ,
   output logic [15:0]              frame_cnt
`endif
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(max_int(FRAME_CYCLES, IFG_CYCLES) + 1);
   localparam logic [CW-1:0] FRAME_LOAD = CW'(FRAME_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

   sched_state_t    state, next_state;
   logic [CW-1:0]   cnt;
   logic [IW-1:0]   ptr;
   logic [NREQ-1:0] arb_winner;
   logic [IW-1:0]   arb_idx;
   logic            launch;

   rr_arb #(.NREQ(NREQ)) u_rr_arb (
      .req    (req),
      .ptr    (ptr),
      .winner (arb_winner),
      .idx    (arb_idx)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Next-state and pulse outputs; a new grant is only considered in IDLE
   always_comb begin
      next_state = state;
      start      = 1'b0;
      gnt        = '0;
      busy       = 1'b1;
      launch     = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (enable && (|arb_winner)) begin
               launch     = 1'b1;
               next_state = ST_START;
            end
         end
         ST_START: begin
            start      = 1'b1;
            gnt        = NREQ'(1) << sel;
            next_state = ST_FRAME;
         end
         ST_FRAME: begin
            if (cnt == '0) next_state = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
         end
         ST_GAP: begin
            if (cnt == '0) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Owner, round-robin pointer and frame/gap down-counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         sel <= '0;
         ptr <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  sel <= arb_idx;
                  ptr <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
               end
            end
            ST_START: cnt <= FRAME_LOAD;
            ST_FRAME: cnt <= (cnt == '0) ? GAP_LOAD : cnt - CW'(1);
            ST_GAP:   if (cnt != '0) cnt <= cnt - CW'(1);
            default:  cnt <= '0;
         endcase
      end
   end

`ifdef ETH_TX_SCHED_STATS_EN
   // Count start pulses, wrapping naturally at 16 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     frame_cnt <= '0;
      else if (start) frame_cnt <= frame_cnt + 16'd1;
   end
`endif

endmodule
